// File: rtl/mem_write_buffer.sv
// Posted write buffer between one writer, one reader and a single-port memory.
// Reads snoop the buffered writes (youngest match wins); misses go to memory.
module mem_write_buffer #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_valid,
   output logic              rd_ready,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_resp_valid,
   output logic [DATA_W-1:0] rd_resp_data,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_data,
   output logic              mem_write_enable,
   output logic              mem_read_enable,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [ADDR_W-1:0] addr_d [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [DATA_W-1:0] data_d [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]    count_q, count_d;
   logic              rd_resp_valid_q, rd_resp_valid_d;
   logic              resp_hit_q, resp_hit_d;
   logic [DATA_W-1:0] hit_data_q, hit_data_d;

   logic              hit;
   logic [DATA_W-1:0] hit_data;
   logic              full;
   logic              drain;
   logic              mem_rd;
   logic              rd_rdy;
   logic              push;
   logic              rd_accept;

   // Oldest-to-youngest scan so the last match seen is the youngest entry.
   always_comb begin
      hit      = 1'b0;
      hit_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (((PTR_W+1)'(i) < count_q) && (addr_q[rd_ptr_q + PTR_W'(i)] == rd_addr)) begin
            hit      = 1'b1;
            hit_data = data_q[rd_ptr_q + PTR_W'(i)];
         end
      end
   end

   // A full buffer must drain to make progress; otherwise a missing read
   // owns the memory port and drains wait.
   always_comb begin
      full   = (count_q == DEPTH_CNT);
      drain  = 1'b0;
      mem_rd = 1'b0;
      rd_rdy = 1'b0;
      if (rst_n) begin
         if (full) begin
            drain = 1'b1;
         end else begin
            rd_rdy = 1'b1;
            if (rd_valid && !hit) begin
               mem_rd = 1'b1;
            end else if (count_q != '0) begin
               drain = 1'b1;
            end
         end
      end
      push      = rst_n && wr_valid && !full;
      rd_accept = rd_valid && rd_rdy;
   end

   always_comb begin
      addr_d   = addr_q;
      data_d   = data_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         addr_d[wr_ptr_q] = wr_addr;
         data_d[wr_ptr_q] = wr_data;
         wr_ptr_d         = wr_ptr_q + PTR_ONE;
      end
      if (drain) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({push, drain})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
      rd_resp_valid_d = rd_accept;
      resp_hit_d      = rd_accept && hit;
      hit_data_d      = (rd_accept && hit) ? hit_data : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         count_q         <= '0;
         rd_resp_valid_q <= 1'b0;
         resp_hit_q      <= 1'b0;
         hit_data_q      <= '0;
      end else begin
         addr_q          <= addr_d;
         data_q          <= data_d;
         wr_ptr_q        <= wr_ptr_d;
         rd_ptr_q        <= rd_ptr_d;
         count_q         <= count_d;
         rd_resp_valid_q <= rd_resp_valid_d;
         resp_hit_q      <= resp_hit_d;
         hit_data_q      <= hit_data_d;
      end
   end

   assign wr_ready         = rst_n && !full;
   assign rd_ready         = rd_rdy;
   assign mem_write_enable = drain;
   assign mem_read_enable  = mem_rd;
   assign mem_address      = drain ? addr_q[rd_ptr_q] : (mem_rd ? rd_addr : '0);
   assign mem_data         = drain ? data_q[rd_ptr_q] : '0;
   assign rd_resp_valid    = rd_resp_valid_q;
   assign rd_resp_data     = !rd_resp_valid_q ? '0 : (resp_hit_q ? hit_data_q : mem_rdata);
   assign empty            = (count_q == '0);

endmodule
